cache_fill_ctrl: RTL

//  Memory-initiator side of the data/instruction cache miss path. On a cache miss, fetches one
//  8-word block from the byte-addressed 16-bit memory and streams each returned word into the cache data array.

---
 rtl/cache_fill_ctrl_if.sv | 33 +++
 rtl/cache_fill_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Cache-miss fill bus: tag-logic miss request, memory read port and data/tag array write port.
// master = fill controller, slave = cache tag logic / memory / data array side.
interface cache_fill_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS      = 8
);
  localparam int IDX_W = $clog2(WORDS);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  fsm_busy;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [IDX_W-1:0]      cache_word_idx;
  logic [15:0]           cache_data_out;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_enable, mem_wr, memory_address,
           write_data_array, write_tag_array, cache_word_idx, cache_data_out
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_enable, mem_wr, memory_address,
           write_data_array, write_tag_array, cache_word_idx, cache_data_out
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: issues one pipelined read per cycle for a WORDS-word block and
// streams returned words into the data array. Define FILL_CRITICAL_FIRST_EN for critical-word-first order.
module cache_fill_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam int HI_W  = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_issue_cnt, w_issue_cnt_nxt;
  logic [CNT_W-1:0] r_ret_cnt, w_ret_cnt_nxt;
  logic [HI_W-1:0]  r_base, w_base_nxt;
  logic [IDX_W-1:0] w_issue_ord, w_ret_ord;
  logic             w_busy, w_accept, w_ret, w_last_ret;

  assign w_busy     = (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) && bus.miss_detected;
  assign w_ret      = w_busy && bus.memory_data_valid;
  assign w_last_ret = w_ret && (r_ret_cnt == CNT_W'(WORDS - 1));

`ifdef FILL_CRITICAL_FIRST_EN
  logic [IDX_W-1:0] r_w0;

  always_ff @(posedge clk) begin
    if (rst)           r_w0 <= '0;
    else if (w_accept) r_w0 <= bus.miss_address[OFF_W-1:1];
  end

  // IDX_W-bit addition wraps modulo WORDS, keeping the word inside the block
  assign w_issue_ord = r_w0 + r_issue_cnt[IDX_W-1:0];
  assign w_ret_ord   = r_w0 + r_ret_cnt[IDX_W-1:0];
`else
  assign w_issue_ord = r_issue_cnt[IDX_W-1:0];
  assign w_ret_ord   = r_ret_cnt[IDX_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_base      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_ret_cnt   <= w_ret_cnt_nxt;
      r_base      <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_issue_cnt_nxt = r_issue_cnt;
    w_ret_cnt_nxt   = r_ret_cnt;
    w_base_nxt      = r_base;
    case (r_state)
      S_IDLE: begin
        if (bus.miss_detected) begin
          w_state_nxt     = S_ISSUE;
          w_base_nxt      = bus.miss_address[ADDR_WIDTH-1:OFF_W];
          w_issue_cnt_nxt = '0;
          w_ret_cnt_nxt   = '0;
        end
      end
      S_ISSUE: begin
        w_issue_cnt_nxt = r_issue_cnt + 1'b1;
        if (r_issue_cnt == CNT_W'(WORDS - 1)) w_state_nxt = S_WAIT;
      end
      S_WAIT:  ;
      default: w_state_nxt = S_IDLE;
    endcase
    // Returns overlap ISSUE, so they are counted independently of the state arm
    if (w_ret) w_ret_cnt_nxt = r_ret_cnt + 1'b1;
    if (w_last_ret) begin
      w_state_nxt     = S_IDLE;
      w_issue_cnt_nxt = '0;
      w_ret_cnt_nxt   = '0;
    end
  end

  assign bus.fsm_busy         = w_busy;
  assign bus.mem_enable       = (r_state == S_ISSUE);
  assign bus.mem_wr           = 1'b0;
  assign bus.memory_address   = (r_state == S_ISSUE) ? {r_base, w_issue_ord, 1'b0} : '0;
  assign bus.write_data_array = w_ret;
  assign bus.write_tag_array  = w_last_ret;
  assign bus.cache_word_idx   = w_ret ? w_ret_ord : '0;
  assign bus.cache_data_out   = w_ret ? bus.memory_data : '0;
endmodule
